// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared constants and types for the up/down load counter
package ctr_pkg;

    localparam int CTR_WIDTH_DEF = 4;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/ctr_flags.sv
// rtl/ctr_flags.sv - combinational status flags and wrap prediction for the counter
module ctr_flags #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             down,
    output logic             rollover,
    output logic             zero,
    output logic             wrap_next
);

    assign rollover  = &count;
    assign zero      = ~|count;
    // A counting step wraps when leaving all-zeros downward or all-ones upward.
    assign wrap_next = down ? zero : rollover;

endmodule

// File: rtl/updown_load_counter.sv
// rtl/updown_load_counter.sv - up/down binary counter with parallel load and wrap pulse
module updown_load_counter
    import ctr_pkg::*;
#(
    parameter int WIDTH = CTR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load,
    input  logic             down,
    output logic [WIDTH-1:0] count,
    output logic             rollover,
    output logic             zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    dir_e             dir;
    logic             wrap_next;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    assign dir = dir_e'(down);

    ctr_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .count     (count),
        .down      (down),
        .rollover  (rollover),
        .zero      (zero),
        .wrap_next (wrap_next)
    );

    // Next-state selection: load wins over counting; loads never flag a wrap.
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (load_en) begin
            next_count = load;
        end else if (dir == DIR_DOWN) begin
            next_count = count - STEP;
            next_wrap  = wrap_next;
        end else begin
            next_count = count + STEP;
            next_wrap  = wrap_next;
        end
    end

    // Counter and wrap-pulse registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

endmodule

// File: tb/tb_updown_load_counter.sv
// tb/tb_updown_load_counter.sv - scoreboard bench for 4-bit and 8-bit counter instances
module tb_updown_load_counter;

    typedef struct {
        string       tag;
        int          lane;
        int unsigned cnt;
        bit          ro;
        bit          z;
        bit          wr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       le [2];
    logic [7:0] ld [2];
    logic       dn [2];

    logic [3:0] count4;
    logic       ro4, z4, w4;
    logic [7:0] count8;
    logic       ro8, z8, w8;

    int unsigned mc [2];
    bit          mw [2];
    exp_t        sb [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    updown_load_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load_en(le[0]), .load(ld[0][3:0]), .down(dn[0]),
        .count(count4), .rollover(ro4), .zero(z4), .wrap(w4)
    );

    updown_load_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_en(le[1]), .load(ld[1]), .down(dn[1]),
        .count(count8), .rollover(ro8), .zero(z8), .wrap(w8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned lane_mask(input int l);
        return (l == 0) ? 32'hF : 32'hFF;
    endfunction

    // Drive one lane at the falling edge, predict both lanes, then compare after the rising edge.
    task automatic step(input string tag, input int l, input bit le_i, input logic [7:0] ld_i, input bit dn_i);
        exp_t e;
        int unsigned m;
        @(negedge clk);
        le[l] = le_i;
        ld[l] = ld_i;
        dn[l] = dn_i;
        for (int k = 0; k < 2; k++) begin
            m = lane_mask(k);
            if (le[k]) begin
                mc[k] = int'(ld[k]) & m;
                mw[k] = 1'b0;
            end else if (dn[k]) begin
                mw[k] = (mc[k] == 0);
                mc[k] = (mc[k] - 1) & m;
            end else begin
                mw[k] = (mc[k] == m);
                mc[k] = (mc[k] + 1) & m;
            end
            e.tag  = tag;
            e.lane = k;
            e.cnt  = mc[k];
            e.ro   = (mc[k] == m);
            e.z    = (mc[k] == 0);
            e.wr   = mw[k];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.lane == 0) begin
                check({e.tag, ".c4"}, 32'(count4), e.cnt);
                check({e.tag, ".r4"}, 32'(ro4), 32'(e.ro));
                check({e.tag, ".z4"}, 32'(z4), 32'(e.z));
                check({e.tag, ".w4"}, 32'(w4), 32'(e.wr));
            end else begin
                check({e.tag, ".c8"}, 32'(count8), e.cnt);
                check({e.tag, ".r8"}, 32'(ro8), 32'(e.ro));
                check({e.tag, ".z8"}, 32'(z8), 32'(e.z));
                check({e.tag, ".w8"}, 32'(w8), 32'(e.wr));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            le[k] = 1'b0;
            ld[k] = 8'h00;
            dn[k] = 1'b0;
            mc[k] = 0;
            mw[k] = 1'b0;
        end

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst.count4", 32'(count4), 0);
        check("rst.zero4", 32'(z4), 1);
        check("rst.ro4", 32'(ro4), 0);
        check("rst.wrap4", 32'(w4), 0);
        check("rst.count8", 32'(count8), 0);
        #1 rst = 1'b0;

        step("up1", 0, 1'b0, 8'h0, 1'b0);
        check("tp.up1", 32'(count4), 1);
        step("up2", 0, 1'b0, 8'h0, 1'b0);
        check("tp.up2", 32'(count4), 2);

        step("ld8", 0, 1'b1, 8'h8, 1'b1);
        check("tp.ld8", 32'(count4), 8);
        step("ld0", 0, 1'b1, 8'h0, 1'b1);
        check("tp.ld0.wrap", 32'(w4), 0);

        step("dnwrap", 0, 1'b0, 8'h0, 1'b1);
        check("tp.dnwrap.c", 32'(count4), 4'hF);
        check("tp.dnwrap.w", 32'(w4), 1);
        step("dnE", 0, 1'b0, 8'h0, 1'b1);
        check("tp.dnE.c", 32'(count4), 4'hE);

        step("ldE", 0, 1'b1, 8'hE, 1'b0);
        step("upF", 0, 1'b0, 8'h0, 1'b0);
        check("tp.upF.ro", 32'(ro4), 1);
        step("up0", 0, 1'b0, 8'h0, 1'b0);
        check("tp.up0.w", 32'(w4), 1);
        step("up1b", 0, 1'b0, 8'h0, 1'b0);
        check("tp.up1b.w", 32'(w4), 0);

        step("ldF", 0, 1'b1, 8'hF, 1'b0);
        check("tp.ldF.w", 32'(w4), 0);

        step("ld5", 0, 1'b1, 8'h5, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("arst.count4", 32'(count4), 0);
        check("arst.zero4", 32'(z4), 1);
        check("arst.wrap4", 32'(w4), 0);
        check("arst.count8", 32'(count8), 0);
        mc[0] = 0; mc[1] = 0; mw[0] = 1'b0; mw[1] = 1'b0;
        le[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        step("resume", 0, 1'b0, 8'h0, 1'b0);
        check("tp.resume", 32'(count4), 1);

        step("w8.ldFE", 1, 1'b1, 8'hFE, 1'b0);
        step("w8.upFF", 1, 1'b0, 8'h00, 1'b0);
        check("tp.w8.FF", 32'(count8), 8'hFF);
        step("w8.up00", 1, 1'b0, 8'h00, 1'b0);
        check("tp.w8.wrap", 32'(w8), 1);
        step("w8.up01", 1, 1'b0, 8'h00, 1'b0);
        check("tp.w8.01", 32'(count8), 1);

        for (int i = 0; i < 60; i++) begin
            int l;
            l = i % 2;
            step("rand", l, ($urandom_range(0, 5) == 0), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
